// File: rtl/pipe_mux.sv
// pipe_mux: N-way select captured into a two-entry skid pipeline.
// Out-of-range selects yield result=0 with sel_err set.
module pipe_mux #(
  parameter  int WIDTH = 32,
  parameter  int N     = 2,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [SELW-1:0]    select,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   result,
  output logic               sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  localparam logic [SELW:0] NV = (SELW+1)'(N);

  state_t           state;
  logic [WIDTH-1:0] main_data;
  logic             main_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic [WIDTH-1:0] dec_data;
  logic             dec_err;
  logic             accept;
  logic             pop;

  always_comb begin
    dec_data = '0;
    dec_err  = ({1'b0, select} >= NV);
    for (int k = 0; k < N; k++) begin
      if (select == SELW'(k))
        dec_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= dec_data;
            main_err  <= dec_err;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= dec_data;
            main_err  <= dec_err;
          end else if (accept) begin
            skid_data <= dec_data;
            skid_err  <= dec_err;
            in_ready  <= 1'b0;
            state     <= TWO;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can change anything
          if (pop) begin
            main_data <= skid_data;
            main_err  <= skid_err;
            in_ready  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign result  = main_data;
  assign sel_err = main_err;

endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux: directed and random checks of pipe_mux (N=5, WIDTH=8)
// against a FIFO-of-beats reference model.
module tb_pipe_mux;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] data_in;
  logic [SW-1:0]  select;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   result;
  logic           sel_err;
  logic           out_valid;
  logic           out_ready;

  int    vectors = 0;
  int    errors  = 0;
  int    n_acc   = 0;
  beat_t q[$];
  bit    after_rst = 1'b1;

  pipe_mux #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .select    (select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .sel_err   (sel_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t ref_beat(input logic [SW-1:0] s,
                                     input logic [N*W-1:0] d);
    beat_t          b;
    logic [N*W-1:0] sh;
    b.e = (int'(s) >= N);
    sh  = d >> (int'(s) * W);
    b.d = b.e ? '0 : sh[W-1:0];
    return b;
  endfunction

  function automatic logic [N*W-1:0] slot(input int k,
                                          input logic [W-1:0] v);
    logic [N*W-1:0] d;
    d = {8'($urandom()), 32'($urandom())};
    d[k*W +: W] = v;
    return d;
  endfunction

  task automatic observe();
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("result", 64'(result), 64'(q[0].d));
      chk("sel_err", 64'(sel_err), 64'(q[0].e));
    end else if (after_rst) begin
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_sel_err", 64'(sel_err), 64'd0);
    end
  endtask

  task automatic step(input logic r, input logic iv,
                      input logic ordy, input logic [SW-1:0] s,
                      input logic [N*W-1:0] d);
    bit acc;
    bit pp;
    reset     = r;
    in_valid  = iv;
    out_ready = ordy;
    select    = s;
    data_in   = d;
    observe();
    acc = !r && iv && (q.size() < 2);
    pp  = !r && ordy && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      after_rst = 1'b1;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_beat(s, d));
        n_acc++;
        after_rst = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int target;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    select    = '0;
    data_in   = '0;
    @(posedge clk);
    @(negedge clk);
    step(1, 1, 1, 0, slot(0, 8'd55));
    // basic select, back-to-back
    step(0, 1, 1, 1, {24'd0, 8'd10, 8'd100});
    step(0, 1, 1, 0, {24'd0, 8'd10, 8'd100});
    step(0, 0, 1, 0, slot(2, 8'd9));
    // out-of-range selects, then a valid top index
    step(0, 1, 1, 3'd5, slot(4, 8'hAA));
    step(0, 1, 1, 3'd7, slot(4, 8'hBB));
    step(0, 1, 1, 3'd4, slot(4, 8'hCC));
    step(0, 0, 1, 0, slot(0, 8'd0));
    step(0, 0, 1, 0, slot(0, 8'd0));
    // fill while stalled, third beat must be refused
    step(0, 1, 0, 0, slot(0, 8'd1));
    step(0, 1, 0, 0, slot(0, 8'd2));
    step(0, 1, 0, 0, slot(0, 8'd3));
    step(0, 1, 0, 2, slot(2, 8'd3));
    step(0, 0, 0, 1, slot(1, 8'd77));
    for (int i = 3; i <= 10; i++)
      step(0, 1, 1, 0, slot(0, 8'(i)));
    // reset while full, overriding accept and pop
    step(0, 1, 0, 0, slot(0, 8'd20));
    step(0, 1, 0, 0, slot(0, 8'd21));
    step(1, 1, 1, 0, slot(0, 8'd22));
    step(0, 1, 1, 0, slot(0, 8'd7));
    step(0, 1, 1, 3, slot(3, 8'd8));
    step(0, 0, 1, 0, slot(0, 8'd0));
    step(0, 0, 1, 0, slot(0, 8'd0));
    // random stalls, 1000 beats
    target = n_acc + 1000;
    for (int c = 0; c < 20000 && n_acc < target; c++)
      step(0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           SW'($urandom_range(0, 7)),
           {8'($urandom()), 32'($urandom())});
    if (n_acc < target)
      chk("beat_budget", 64'(n_acc), 64'(target));
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 0, slot(0, 8'd0));
    chk("drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
